// File: rtl/button_reader.sv
// Push-button reader: 2-flop synchronizer, 4-state debounce FSM, press/release pulses
// and a wrapping press counter with synchronous clear.
`default_nettype none

module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_button,
  input  logic                   i_clear,
  output logic                   o_level,
  output logic                   o_press,
  output logic                   o_release,
  output logic [COUNT_WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  // Entering a confirm state already counts as the first agreeing sample.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic                   ff1_q;
  logic                   ff2_q;
  state_t                 state_q;
  logic [15:0]            cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   press_d;

  always_comb begin
    press_d = (state_q == CONFIRM_PRESS) && ff2_q && (cnt_q == CNT_LAST);
  end

  // Clear takes priority over an increment landing on the same edge.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (press_d) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      ff1_q     <= 1'b0;
      ff2_q     <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      ff1_q     <= i_button;
      ff2_q     <= ff1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= count_d;
      case (state_q)
        RELEASED: begin
          if (ff2_q) begin
            state_q <= CONFIRM_PRESS;
            cnt_q   <= 16'd1;
          end
        end
        CONFIRM_PRESS: begin
          if (!ff2_q) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        PRESSED: begin
          if (!ff2_q) begin
            state_q <= CONFIRM_RELEASE;
            cnt_q   <= 16'd1;
          end
        end
        CONFIRM_RELEASE: begin
          if (ff2_q) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_button_reader.sv
// Directed bench for button_reader (DEBOUNCE_CYCLES=4, COUNT_WIDTH=8); inputs driven
// and outputs sampled on the falling clock edge.
`default_nettype none

module tb_button_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button;
  logic       clear;
  logic       level;
  logic       press;
  logic       rel;
  logic [7:0] count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  button_reader #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH    (8)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_button (button),
    .i_clear  (clear),
    .o_level  (level),
    .o_press  (press),
    .o_release(rel),
    .o_count  (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Button level was just changed at this falling edge (next rising edge is E0);
  // the pulse must appear only after edge E0+5 and last one cycle.
  task automatic expect_pulse(input string tag, input bit is_press);
    cyc(5);
    check({tag, "_early"}, is_press ? press : rel, 1'b0);
    cyc(1);
    check({tag, "_pulse"}, is_press ? press : rel, 1'b1);
    check({tag, "_level"}, level, is_press);
    check({tag, "_other"}, is_press ? rel : press, 1'b0);
    cyc(1);
    check({tag, "_one_cycle"}, is_press ? press : rel, 1'b0);
  endtask

  task automatic quick_press();
    button = 1'b1;
    cyc(7);
    button = 1'b0;
    cyc(7);
  endtask

  initial begin
    bit seen;

    // Reset held three cycles with the button already down.
    rst_n  = 1'b0;
    button = 1'b1;
    clear  = 1'b1;
    cyc(1);
    check("rst_level", level, 1'b0);
    check("rst_press", press, 1'b0);
    check("rst_release", rel, 1'b0);
    check("rst_count", count, 8'd0);
    cyc(2);
    check("rst_press_held", press, 1'b0);
    check("rst_level_held", level, 1'b0);
    clear = 1'b0;
    rst_n = 1'b1;
    expect_pulse("post_rst_press", 1'b1);
    check("post_rst_count", count, 8'd1);

    button = 1'b0;
    expect_pulse("release", 1'b0);
    check("release_count", count, 8'd1);

    button = 1'b1;
    expect_pulse("clean_press", 1'b1);
    check("clean_count", count, 8'd2);
    button = 1'b0;
    cyc(7);

    // Bounce: 3 samples high, 1 low, five times; never reaches 4 agreeing samples.
    seen = 1'b0;
    repeat (5) begin
      button = 1'b1;
      repeat (3) begin
        cyc(1);
        seen = seen | press | level;
      end
      button = 1'b0;
      cyc(1);
      seen = seen | press | level;
    end
    repeat (6) begin
      cyc(1);
      seen = seen | press | level;
    end
    check("bounce_no_press", seen, 1'b0);
    check("bounce_count", count, 8'd2);
    check("bounce_level", level, 1'b0);

    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_count", count, 8'd0);

    repeat (255) quick_press();
    check("count_255", count, 8'd255);
    quick_press();
    check("wrap_count", count, 8'd0);
    repeat (3) quick_press();
    check("after_wrap_count", count, 8'd3);

    // Clear on the very edge that accepts the 4th press.
    button = 1'b1;
    cyc(5);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_vs_press_count", count, 8'd0);
    check("clear_vs_press_pulse", press, 1'b1);
    check("clear_vs_press_level", level, 1'b1);
    button = 1'b0;
    cyc(7);
    check("clear_release_level", level, 1'b0);

    // Reset while in CONFIRM_PRESS with cnt=2 (after E0+3), button kept held.
    button = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("midrst_press", press, 1'b0);
    check("midrst_level", level, 1'b0);
    check("midrst_cnt", dut.cnt_q, 16'd0);
    expect_pulse("rearm_press", 1'b1);
    check("rearm_count", count, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
